// File: rtl/spi_arb_pkg.sv
// Shared definitions for the two-source SPI stream arbiter.
//   arb_state_t : frame sequencing states of the arbiter FSM
//   BIT_CNT_W   : width of the bit-within-byte counter
//   DIV_CNT_W   : width of the sclk half-period divider counter
//   rr_pick()   : round-robin pick between two requesters
package spi_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_SHIFT    = 2'd1,
        ST_BYTE_END = 2'd2,
        ST_GAP      = 2'd3
    } arb_state_t;

    localparam int BIT_CNT_W = 3;
    localparam int DIV_CNT_W = 8;
    localparam int BYTE_W    = 8;

    // With both sources requesting, the one not granted last wins;
    // a sole requester always wins.
    function automatic logic rr_pick(input logic req0, input logic req1,
                                     input logic last_grant);
        if (req0 && req1) begin
            return ~last_grant;
        end
        return req1;
    endfunction

endpackage

// File: rtl/spi_byte_shifter.sv
// One-byte SPI mode-0 shift engine.
//   clk, rst_n   : system clock, asynchronous active-low reset
//   i_load       : start a byte with i_data (only pulsed while idle)
//   i_data       : byte to transmit, MSB first
//   i_miso       : serial input, sampled on each sclk rising edge
//   o_sclk       : SPI clock, low CLK_DIV cycles then high CLK_DIV cycles per bit
//   o_mosi       : serial output, changes when a low phase begins
//   o_rx_data    : received byte, complete once o_done is seen
//   o_done       : high in the final clk cycle of the byte (16*CLK_DIV cycles after load)
module spi_byte_shifter
    import spi_arb_pkg::*;
#(
    parameter int CLK_DIV = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_load,
    input  logic [BYTE_W-1:0] i_data,
    input  logic              i_miso,
    output logic              o_sclk,
    output logic              o_mosi,
    output logic [BYTE_W-1:0] o_rx_data,
    output logic              o_done
);

    localparam logic [DIV_CNT_W-1:0] DIV_LAST = DIV_CNT_W'(CLK_DIV - 1);
    localparam logic [BIT_CNT_W-1:0] BIT_LAST = {BIT_CNT_W{1'b1}};

    logic [BYTE_W-1:0]    r_tx_shreg;
    logic [BYTE_W-1:0]    r_rx_shreg;
    logic [DIV_CNT_W-1:0] r_div_cnt;
    logic [BIT_CNT_W-1:0] r_bit_cnt;
    logic                 r_sclk;
    logic                 r_active;
    logic                 w_phase_end;

    assign w_phase_end = (r_div_cnt == DIV_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tx_shreg <= '0;
            r_rx_shreg <= '0;
            r_div_cnt  <= '0;
            r_bit_cnt  <= '0;
            r_sclk     <= 1'b0;
            r_active   <= 1'b0;
        end else if (i_load) begin
            r_tx_shreg <= i_data;
            r_div_cnt  <= '0;
            r_bit_cnt  <= '0;
            r_sclk     <= 1'b0;
            r_active   <= 1'b1;
        end else if (r_active) begin
            if (w_phase_end) begin
                r_div_cnt <= '0;
                if (!r_sclk) begin
                    // Low phase ends: sclk rises, capture miso.
                    r_sclk     <= 1'b1;
                    r_rx_shreg <= {r_rx_shreg[BYTE_W-2:0], i_miso};
                end else begin
                    // High phase ends: sclk falls and the next bit is presented.
                    r_sclk     <= 1'b0;
                    r_tx_shreg <= {r_tx_shreg[BYTE_W-2:0], 1'b0};
                    if (r_bit_cnt == BIT_LAST) begin
                        r_active <= 1'b0;
                    end else begin
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                    end
                end
            end else begin
                r_div_cnt <= r_div_cnt + 1'b1;
            end
        end
    end

    assign o_sclk    = r_sclk;
    assign o_mosi    = r_tx_shreg[BYTE_W-1];
    assign o_rx_data = r_rx_shreg;
    assign o_done    = r_active && w_phase_end && r_sclk && (r_bit_cnt == BIT_LAST);

endmodule

// File: rtl/spi_stream_arbiter.sv
// Two-source byte-stream arbiter driving one SPI mode-0 master.
// Sources hold srcN_cs_n low for a frame and present bytes on srcN_data;
// each consumed byte is acknowledged with a one-cycle srcN_ready pulse.
// Frames are granted round-robin; consecutive bytes of a frame keep
// spi_cs_n low, and frames are separated by at least CS_GAP cycles.
//   clk, rst_n                  : system clock, asynchronous active-low reset
//   src0_cs_n/data/ready        : source 0 request, byte, consume pulse
//   src1_cs_n/data/ready        : source 1 request, byte, consume pulse
//   spi_sclk/cs_n/mosi/miso     : SPI master pins
//   rx_data, rx_valid, rx_src   : received byte, its strobe and owning source
//   busy                        : high whenever a frame or gap is in progress
module spi_stream_arbiter
    import spi_arb_pkg::*;
#(
    parameter int CLK_DIV = 2,
    parameter int CS_GAP  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              src0_cs_n,
    input  logic [BYTE_W-1:0] src0_data,
    output logic              src0_ready,
    input  logic              src1_cs_n,
    input  logic [BYTE_W-1:0] src1_data,
    output logic              src1_ready,
    output logic              spi_sclk,
    output logic              spi_cs_n,
    output logic              spi_mosi,
    input  logic              spi_miso,
    output logic [BYTE_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              rx_src,
    output logic              busy
);

    localparam logic [DIV_CNT_W-1:0] GAP_LAST = DIV_CNT_W'(CS_GAP - 1);

    arb_state_t           r_state;
    arb_state_t           w_state_next;
    logic                 r_grant;
    logic                 r_last_grant;
    logic [DIV_CNT_W-1:0] r_gap_cnt;
    logic [1:0]           r_ready;
    logic                 r_rx_valid;
    logic [BYTE_W-1:0]    r_rx_data;
    logic                 r_rx_src;

    logic [1:0]           w_src_cs_n;
    logic [1:0]           w_req;
    logic                 w_load;
    logic                 w_load_src;
    logic                 w_enter_gap;
    logic [BYTE_W-1:0]    w_load_data;
    logic                 w_sclk;
    logic                 w_mosi;
    logic [BYTE_W-1:0]    w_rx_byte;
    logic                 w_done;

    assign w_src_cs_n = {src1_cs_n, src0_cs_n};

    for (genvar gi = 0; gi < 2; gi++) begin : g_req
        assign w_req[gi] = ~w_src_cs_n[gi];
    end

    assign w_load_data = w_load_src ? src1_data : src0_data;

    spi_byte_shifter #(
        .CLK_DIV (CLK_DIV)
    ) u_shifter (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_load    (w_load),
        .i_data    (w_load_data),
        .i_miso    (spi_miso),
        .o_sclk    (w_sclk),
        .o_mosi    (w_mosi),
        .o_rx_data (w_rx_byte),
        .o_done    (w_done)
    );

    // Requests are only looked at in IDLE and BYTE_END, so a source
    // dropping cs_n mid-byte simply lets the current byte finish.
    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_load_src   = r_grant;
        w_enter_gap  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (|w_req) begin
                    w_load       = 1'b1;
                    w_load_src   = rr_pick(w_req[0], w_req[1], r_last_grant);
                    w_state_next = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (w_done) begin
                    w_state_next = ST_BYTE_END;
                end
            end
            ST_BYTE_END: begin
                if (w_req[r_grant]) begin
                    w_load       = 1'b1;
                    w_state_next = ST_SHIFT;
                end else begin
                    w_enter_gap  = 1'b1;
                    w_state_next = ST_GAP;
                end
            end
            ST_GAP: begin
                if (r_gap_cnt == GAP_LAST) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_grant      <= 1'b0;
            r_last_grant <= 1'b1;
            r_gap_cnt    <= '0;
            r_ready      <= 2'b00;
            r_rx_valid   <= 1'b0;
            r_rx_data    <= '0;
            r_rx_src     <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_load) begin
                r_grant <= w_load_src;
            end
            // Ready is a registered acknowledge, high in the cycle after the
            // byte was latched, so the source may change data from then on.
            r_ready <= w_load ? (w_load_src ? 2'b10 : 2'b01) : 2'b00;
            // The byte's last rising-edge sample happened CLK_DIV cycles ago,
            // so the receive register is complete on the final SHIFT cycle.
            r_rx_valid <= (r_state == ST_SHIFT) && w_done;
            if ((r_state == ST_SHIFT) && w_done) begin
                r_rx_data <= w_rx_byte;
                r_rx_src  <= r_grant;
            end
            if (w_enter_gap) begin
                r_last_grant <= r_grant;
                r_gap_cnt    <= '0;
            end else if (r_state == ST_GAP) begin
                r_gap_cnt <= r_gap_cnt + 1'b1;
            end
        end
    end

    assign src0_ready = r_ready[0];
    assign src1_ready = r_ready[1];
    // The shifter holds sclk low whenever no byte is in flight.
    assign spi_sclk   = w_sclk;
    assign spi_cs_n   = !((r_state == ST_SHIFT) || (r_state == ST_BYTE_END));
    assign spi_mosi   = (r_state == ST_SHIFT) && w_mosi;
    assign rx_data    = r_rx_data;
    assign rx_valid   = r_rx_valid;
    assign rx_src     = r_rx_src;
    assign busy       = (r_state != ST_IDLE);

endmodule

// File: tb/tb_spi_stream_arbiter.sv
module tb_spi_stream_arbiter;

    localparam int CLK_DIV = 2;
    localparam int CS_GAP  = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       src0_cs_n = 1'b1;
    logic [7:0] src0_data = 8'h00;
    logic       src0_ready;
    logic       src1_cs_n = 1'b1;
    logic [7:0] src1_data = 8'h00;
    logic       src1_ready;
    logic       spi_sclk;
    logic       spi_cs_n;
    logic       spi_mosi;
    logic       spi_miso;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_src;
    logic       busy;

    assign spi_miso = spi_mosi;

    always #5 clk = ~clk;

    spi_stream_arbiter #(
        .CLK_DIV (CLK_DIV),
        .CS_GAP  (CS_GAP)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .src0_cs_n  (src0_cs_n),
        .src0_data  (src0_data),
        .src0_ready (src0_ready),
        .src1_cs_n  (src1_cs_n),
        .src1_data  (src1_data),
        .src1_ready (src1_ready),
        .spi_sclk   (spi_sclk),
        .spi_cs_n   (spi_cs_n),
        .spi_mosi   (spi_mosi),
        .spi_miso   (spi_miso),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_src     (rx_src),
        .busy       (busy)
    );

    int tests = 0;
    int fails = 0;
    int cycle = 0;

    // Passive observation logs, filled on every falling clock edge.
    bit         mosi_q[$];
    int         lo_runs[$];
    int         hi_runs[$];
    logic [8:0] rx_q[$];
    int         rdy0_q[$];
    int         rdy1_q[$];
    int         lo_run = 0;
    int         hi_run = 0;
    logic       prev_sclk = 1'b0;

    always @(negedge clk) begin
        cycle = cycle + 1;
        if (spi_sclk && !prev_sclk) mosi_q.push_back(spi_mosi);
        prev_sclk = spi_sclk;
        if (!spi_cs_n) begin
            lo_run = lo_run + 1;
            if (hi_run > 0) begin hi_runs.push_back(hi_run); hi_run = 0; end
        end else begin
            hi_run = hi_run + 1;
            if (lo_run > 0) begin lo_runs.push_back(lo_run); lo_run = 0; end
        end
        if (rx_valid) rx_q.push_back({rx_src, rx_data});
        if (src0_ready) rdy0_q.push_back(cycle);
        if (src1_ready) rdy1_q.push_back(cycle);
    end

    task automatic clear_logs();
        @(posedge clk);
        mosi_q.delete();
        lo_runs.delete();
        hi_runs.delete();
        rx_q.delete();
        rdy0_q.delete();
        rdy1_q.delete();
        lo_run = 0;
        hi_run = 0;
    endtask

    task automatic wait_ready(input int src, input int max, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max; i++) begin
            @(negedge clk);
            if ((src == 0 && src0_ready) || (src == 1 && src1_ready)) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_idle(input int max, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max; i++) begin
            @(negedge clk);
            if (!busy) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic print_rx();
        foreach (rx_q[i]) $display("[TB] rx src=%0d data=%02h", rx_q[i][8], rx_q[i][7:0]);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        src0_cs_n = 1'b1;
        src1_cs_n = 1'b1;
        repeat (3) @(negedge clk);
        tests++; if (spi_cs_n !== 1'b1) begin fails++; $display("FAIL reset_cs_n: got %b want 1", spi_cs_n); end
        tests++; if (spi_sclk !== 1'b0) begin fails++; $display("FAIL reset_sclk: got %b want 0", spi_sclk); end
        tests++; if (spi_mosi !== 1'b0) begin fails++; $display("FAIL reset_mosi: got %b want 0", spi_mosi); end
        tests++; if ({src1_ready, src0_ready} !== 2'b00) begin fails++; $display("FAIL reset_ready: got %b want 00", {src1_ready, src0_ready}); end
        tests++; if (rx_valid !== 1'b0) begin fails++; $display("FAIL reset_rx_valid: got %b want 0", rx_valid); end
        tests++; if (rx_data !== 8'h00) begin fails++; $display("FAIL reset_rx_data: got %02h want 00", rx_data); end
        tests++; if (rx_src !== 1'b0) begin fails++; $display("FAIL reset_rx_src: got %b want 0", rx_src); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", busy); end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        tests++; if (busy !== 1'b0 || spi_cs_n !== 1'b1) begin fails++; $display("FAIL idle_no_req: busy=%b cs_n=%b want 0/1", busy, spi_cs_n); end
        $display("[TB] reset done");
    endtask

    task automatic test_single_byte();
        bit ok;
        logic [7:0] bits;
        clear_logs();
        @(negedge clk);
        src0_data = 8'hA5;
        src0_cs_n = 1'b0;
        wait_ready(0, 20, ok);
        src0_cs_n = 1'b1;
        tests++; if (!ok) begin fails++; $display("FAIL single_ready: got timeout want pulse"); end
        wait_idle(200, ok);
        tests++; if (!ok) begin fails++; $display("FAIL single_idle: got timeout want idle"); end
        bits = 8'h00;
        for (int i = 0; i < mosi_q.size() && i < 8; i++) bits = {bits[6:0], mosi_q[i]};
        tests++; if (mosi_q.size() != 8 || bits !== 8'hA5) begin fails++; $display("FAIL single_mosi: got %0d bits %02h want 8 bits a5", mosi_q.size(), bits); end
        tests++; if (lo_runs.size() != 1 || lo_runs[0] != 33) begin fails++; $display("FAIL single_cs_low: got %0d runs first %0d want 1 run of 33", lo_runs.size(), (lo_runs.size() > 0) ? lo_runs[0] : -1); end
        tests++; if (rx_q.size() != 1 || rx_q[0] !== {1'b0, 8'hA5}) begin fails++; $display("FAIL single_rx: got %0d entries first %03h want 1 entry 0a5", rx_q.size(), (rx_q.size() > 0) ? rx_q[0] : 9'h1ff); end
        tests++; if (rdy0_q.size() != 1 || rdy1_q.size() != 0) begin fails++; $display("FAIL single_ready_cnt: got %0d/%0d want 1/0", rdy0_q.size(), rdy1_q.size()); end
        print_rx();
    endtask

    task automatic test_multi_byte();
        bit ok;
        int n;
        clear_logs();
        @(negedge clk);
        src1_data = 8'h01;
        src1_cs_n = 1'b0;
        n = 0;
        for (int i = 0; i < 400 && n < 3; i++) begin
            @(negedge clk);
            if (src1_ready) begin
                n++;
                if (n == 1) src1_data = 8'h02;
                if (n == 2) src1_data = 8'h03;
                if (n == 3) src1_cs_n = 1'b1;
            end
        end
        src1_cs_n = 1'b1;
        tests++; if (n != 3) begin fails++; $display("FAIL multi_ready_seen: got %0d want 3", n); end
        wait_idle(200, ok);
        tests++; if (!ok) begin fails++; $display("FAIL multi_idle: got timeout want idle"); end
        tests++; if (lo_runs.size() != 1 || lo_runs[0] != 99) begin fails++; $display("FAIL multi_cs_low: got %0d runs first %0d want 1 run of 99", lo_runs.size(), (lo_runs.size() > 0) ? lo_runs[0] : -1); end
        tests++; if (rdy1_q.size() != 3 || rdy1_q[1] - rdy1_q[0] != 33 || rdy1_q[2] - rdy1_q[1] != 33) begin fails++; $display("FAIL multi_ready_spacing: got %0d pulses want 3 spaced 33", rdy1_q.size()); end
        tests++; if (rdy0_q.size() != 0) begin fails++; $display("FAIL multi_other_ready: got %0d want 0", rdy0_q.size()); end
        tests++; if (rx_q.size() != 3 || rx_q[0] !== 9'h101 || rx_q[1] !== 9'h102 || rx_q[2] !== 9'h103) begin fails++; $display("FAIL multi_rx: got %0d entries want 101,102,103", rx_q.size()); end
        print_rx();
    endtask

    task automatic test_round_robin();
        bit ok;
        int rem0, rem1, nrx;
        bit pend0, pend1;
        rst_n = 1'b0;
        src0_data = 8'h11;
        src1_data = 8'h22;
        src0_cs_n = 1'b0;
        src1_cs_n = 1'b0;
        repeat (2) @(negedge clk);
        clear_logs();
        @(negedge clk);
        rst_n = 1'b1;
        rem0 = 2; rem1 = 2; nrx = 0; pend0 = 0; pend1 = 0;
        for (int i = 0; i < 1000 && nrx < 4; i++) begin
            @(negedge clk);
            if (pend0) begin src0_cs_n = 1'b0; pend0 = 0; end
            if (pend1) begin src1_cs_n = 1'b0; pend1 = 0; end
            if (src0_ready) begin src0_cs_n = 1'b1; rem0--; end
            if (src1_ready) begin src1_cs_n = 1'b1; rem1--; end
            if (rx_valid) begin
                nrx++;
                if (rx_src == 1'b0 && rem0 > 0) pend0 = 1;
                if (rx_src == 1'b1 && rem1 > 0) pend1 = 1;
            end
        end
        src0_cs_n = 1'b1;
        src1_cs_n = 1'b1;
        wait_idle(200, ok);
        tests++; if (!ok || nrx != 4) begin fails++; $display("FAIL rr_done: got %0d bytes want 4", nrx); end
        tests++; if (rx_q.size() != 4 || rx_q[0] !== 9'h011 || rx_q[1] !== 9'h122 || rx_q[2] !== 9'h011 || rx_q[3] !== 9'h122) begin fails++; $display("FAIL rr_order: got %0d entries want 011,122,011,122", rx_q.size()); end
        tests++; if (hi_runs.size() != 4 || hi_runs[1] < CS_GAP || hi_runs[2] < CS_GAP || hi_runs[3] < CS_GAP) begin fails++; $display("FAIL rr_gap: got %0d high runs want 4 with gaps >= %0d", hi_runs.size(), CS_GAP); end
        tests++; if (rdy0_q.size() != 2 || rdy1_q.size() != 2) begin fails++; $display("FAIL rr_ready_cnt: got %0d/%0d want 2/2", rdy0_q.size(), rdy1_q.size()); end
        print_rx();
    endtask

    task automatic test_early_release();
        bit ok;
        clear_logs();
        @(negedge clk);
        src0_data = 8'h3C;
        src0_cs_n = 1'b0;
        wait_ready(0, 20, ok);
        tests++; if (!ok) begin fails++; $display("FAIL early_ready: got timeout want pulse"); end
        repeat (4) @(negedge clk);
        src0_cs_n = 1'b1;
        wait_idle(200, ok);
        tests++; if (!ok) begin fails++; $display("FAIL early_idle: got timeout want idle"); end
        tests++; if (rx_q.size() != 1 || rx_q[0] !== {1'b0, 8'h3C}) begin fails++; $display("FAIL early_rx: got %0d entries first %03h want 1 entry 03c", rx_q.size(), (rx_q.size() > 0) ? rx_q[0] : 9'h1ff); end
        tests++; if (lo_runs.size() != 1 || lo_runs[0] != 33) begin fails++; $display("FAIL early_cs_low: got %0d runs first %0d want 1 run of 33", lo_runs.size(), (lo_runs.size() > 0) ? lo_runs[0] : -1); end
        print_rx();
    endtask

    task automatic test_reset_mid_byte();
        bit ok;
        bit went_busy;
        clear_logs();
        @(negedge clk);
        src1_data = 8'h5A;
        src1_cs_n = 1'b0;
        wait_ready(1, 20, ok);
        tests++; if (!ok) begin fails++; $display("FAIL midrst_ready: got timeout want pulse"); end
        repeat (9) @(negedge clk);
        tests++; if (spi_cs_n !== 1'b0) begin fails++; $display("FAIL midrst_in_byte: got cs_n %b want 0", spi_cs_n); end
        rst_n = 1'b0;
        #1;
        tests++; if (spi_cs_n !== 1'b1 || spi_sclk !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL midrst_abort: got cs_n %b sclk %b busy %b want 1 0 0", spi_cs_n, spi_sclk, busy); end
        src1_cs_n = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        went_busy = 0;
        repeat (60) begin
            @(negedge clk);
            if (busy) went_busy = 1;
        end
        tests++; if (went_busy || rx_q.size() != 0) begin fails++; $display("FAIL midrst_quiet: got busy %b rx %0d want 0 0", went_busy, rx_q.size()); end
        clear_logs();
        @(negedge clk);
        src0_data = 8'hC3;
        src0_cs_n = 1'b0;
        wait_ready(0, 20, ok);
        src0_cs_n = 1'b1;
        tests++; if (!ok) begin fails++; $display("FAIL midrst_restart_ready: got timeout want pulse"); end
        wait_idle(200, ok);
        tests++; if (!ok || rx_q.size() != 1 || rx_q[0] !== {1'b0, 8'hC3}) begin fails++; $display("FAIL midrst_restart_rx: got %0d entries want 1 entry 0c3", rx_q.size()); end
        tests++; if (lo_runs.size() != 1 || lo_runs[0] != 33) begin fails++; $display("FAIL midrst_restart_cs: got %0d runs first %0d want 1 run of 33", lo_runs.size(), (lo_runs.size() > 0) ? lo_runs[0] : -1); end
        print_rx();
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_multi_byte();
        test_round_robin();
        test_early_release();
        test_reset_mid_byte();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got no completion want finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/spi_stream_arbiter.md
SPI_STREAM_ARBITER -- requirements
Module: spi_stream_arbiter

Interface
REQ-001 Parameter CLK_DIV, default 2, SPI half-period in clk cycles; legal range 1..255.
REQ-002 Parameter CS_GAP, default 2, minimum clk cycles with spi_cs_n high between frames; legal range 1..255.
REQ-003 clk  in  1  single system clock; all logic on rising edge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 src0_cs_n  in  1  source 0 frame request, active-low.
REQ-006 src0_data  in  8  source 0 byte to transmit.
REQ-007 src0_ready  out  1  one-cycle pulse: src0_data consumed; source advances to next byte.
REQ-008 src1_cs_n, src1_data, src1_ready  same as REQ-005..007 for source 1.
REQ-009 spi_sclk  out  1  SPI clock, mode 0 (CPOL=0, CPHA=0).
REQ-010 spi_cs_n  out  1  SPI chip select, active-low.
REQ-011 spi_mosi  out  1  serial data out, MSB first.
REQ-012 spi_miso  in  1  serial data in.
REQ-013 rx_data  out  8  byte received during the last completed byte.
REQ-014 rx_valid  out  1  one-cycle pulse qualifying rx_data.
REQ-015 rx_src  out  1  source index owning the completed byte.
REQ-016 busy  out  1  high whenever state is not IDLE.

Function
REQ-017 The block SHALL implement states IDLE, SHIFT, BYTE_END, GAP.
REQ-018 IDLE: if any srcN_cs_n is low, grant one source, latch its data, pulse its srcN_ready for 1 cycle, enter SHIFT; otherwise remain in IDLE.
REQ-019 Arbitration SHALL be round-robin at frame granularity: with both requesting, grant the source not granted last; a sole requester is always granted.
REQ-020 SHIFT: spi_cs_n low; 8 bits, each bit = CLK_DIV cycles sclk low then CLK_DIV cycles sclk high; mosi updates on entry to each low phase; miso sampled on each sclk rising edge.
REQ-021 Byte time SHALL be 16*CLK_DIV SHIFT cycles plus 1 BYTE_END cycle; sclk low in BYTE_END.
REQ-022 BYTE_END: pulse rx_valid with rx_data and rx_src; if the granted source's cs_n is low, latch its next byte, pulse its ready in the same cycle, and return to SHIFT with spi_cs_n held low; otherwise enter GAP.
REQ-023 GAP: spi_cs_n high, sclk low, mosi low for CS_GAP cycles, then IDLE; update last-grant on GAP entry.
REQ-024 srcN_cs_n SHALL be sampled only in IDLE and BYTE_END; changes mid-byte are ignored and the current byte completes.
REQ-025 The non-granted source's ready SHALL stay low for the whole frame.
REQ-026 Bit counter 3 bits, divider counter 8 bits; neither wraps outside its defined range.

Reset
REQ-027 On rst_n low, asynchronously: state IDLE, spi_cs_n=1, spi_sclk=0, spi_mosi=0, srcN_ready=0, rx_valid=0, rx_data=0x00, rx_src=0, busy=0, last-grant=1 (source 0 wins first tie).
REQ-028 Reset asserted mid-frame SHALL abort the byte with no rx_valid; after release the block waits in IDLE.

Structure
REQ-029 A package spi_arb_pkg SHALL hold the state enumeration and the counter width constants.
REQ-030 Shift/divider datapath SHALL be one sub-module, spi_byte_shifter (load, 8-bit shift, sclk generation, done pulse); arbitration and FSM stay in the top.

Verification (CLK_DIV=2, CS_GAP=2, miso looped to mosi unless stated)
REQ-031 Reset: all outputs hold REQ-027 values; busy=0 with no requests.
REQ-032 src0 sends 0xA5 single byte -> mosi bits 1,0,1,0,0,1,0,1 at rising sclk edges; spi_cs_n low exactly 33 cycles; rx_valid once, rx_data=0xA5, rx_src=0.
REQ-033 src1 frame 0x01,0x02,0x03 -> spi_cs_n low 99 contiguous cycles; src1_ready 3 pulses 33 cycles apart; rx_data 0x01,0x02,0x03 with rx_src=1.
REQ-034 Both sources request from reset, one byte each, repeated twice -> grant order 0,1,0,1; spi_cs_n high >=2 cycles between frames.
REQ-035 src0_cs_n raised 5 cycles into a byte -> byte completes, rx_valid pulses, frame ends at BYTE_END.
REQ-036 rst_n low for 1 cycle mid-byte -> spi_cs_n=1, sclk=0 immediately, no rx_valid; next request restarts cleanly.
